binclk_timekeeper: RTL and testbench

Time-keeping core of the binary clock. Divides the system clock down to a 1 Hz tick and maintains registered HH:MM:SS counters. Accepts two debounced set buttons for hours and minutes. Its outputs feed the binary display/output-mux stage that drives `uo_out`; its inputs come from the top-level `ui_in` pins and `ena`.

---
 rtl/binclk_timekeeper.sv | 68 ++++++
 tb/tb_binclk_timekeeper.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/binclk_timekeeper.sv
// binclk_timekeeper: 1 Hz prescaler plus registered HH:MM:SS counters with hour/minute set buttons.
// Define BINCLK_12H_EN for 12-hour mode (hours 1-12, pm toggles on 11->12).
module binclk_timekeeper #(
  parameter int CLK_HZ = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       btn_hr,
  input  logic       btn_min,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       pm,
  output logic       sec_pulse
);
  localparam int PW = $clog2(CLK_HZ);
`ifdef BINCLK_12H_EN
  localparam logic [4:0] H_RST = 5'd12;
`else
  localparam logic [4:0] H_RST = 5'd0;
`endif
  logic [PW-1:0] presc, presc_n;
  logic btn_hr_q, btn_min_q, hr_ev, min_ev, tick, do_tick, sec_wrap, min_inc, hr_inc, pm_n;
  logic [4:0] hours_n;
  logic [5:0] minutes_n, seconds_n;
  always_comb begin
    hr_ev = btn_hr & ~btn_hr_q;
    min_ev = btn_min & ~btn_min_q;
    tick = ena && presc == PW'(CLK_HZ - 1);
    do_tick = tick & ~hr_ev & ~min_ev;
    sec_wrap = seconds == 6'd59;
    min_inc = min_ev | (do_tick & sec_wrap);
    hr_inc = hr_ev | (do_tick & sec_wrap & minutes == 6'd59);
    presc_n = min_ev ? '0 : !ena ? presc : tick ? '0 : presc + PW'(1);
    seconds_n = min_ev ? '0 : !do_tick ? seconds : sec_wrap ? '0 : seconds + 6'd1;
    minutes_n = !min_inc ? minutes : minutes == 6'd59 ? '0 : minutes + 6'd1;
`ifdef BINCLK_12H_EN
    hours_n = !hr_inc ? hours : hours == 5'd12 ? 5'd1 : hours + 5'd1;
    pm_n = pm ^ (hr_inc && hours == 5'd11);
`else
    hours_n = !hr_inc ? hours : hours == 5'd23 ? '0 : hours + 5'd1;
    pm_n = 1'b0;
`endif
  end
  // history regs reset high so a button held through reset is ignored until re-pressed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      hours <= H_RST;
      minutes <= '0;
      seconds <= '0;
      pm <= 1'b0;
      sec_pulse <= 1'b0;
      btn_hr_q <= 1'b1;
      btn_min_q <= 1'b1;
    end else begin
      presc <= presc_n;
      hours <= hours_n;
      minutes <= minutes_n;
      seconds <= seconds_n;
      pm <= pm_n;
      sec_pulse <= do_tick;
      btn_hr_q <= btn_hr;
      btn_min_q <= btn_min;
    end
  end
endmodule

// File: tb/tb_binclk_timekeeper.sv
// tb_binclk_timekeeper: scoreboard bench for binclk_timekeeper at CLK_HZ=4.
// Honours BINCLK_12H_EN for the expected hour/pm behaviour.
module tb_binclk_timekeeper;
  localparam int CLK_HZ = 4;
`ifdef BINCLK_12H_EN
  localparam int H0 = 12, HR_PRESS = 11, H_TOP = 11, PM_ROLL = 1;
`else
  localparam int H0 = 0, HR_PRESS = 23, H_TOP = 23, PM_ROLL = 0;
`endif
  typedef struct {int h; int m; int s; int pm; int pulse;} exp_t;
  logic clk, rst, ena, btn_hr, btn_min;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic pm, sec_pulse;
  exp_t sb[$];
  int n_chk, n_fail;
  int m_h, m_m, m_s, m_pm, m_pulse, m_presc, m_hq, m_mq;
  int saved_s;

  binclk_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst(rst), .ena(ena), .btn_hr(btn_hr), .btn_min(btn_min),
    .hours(hours), .minutes(minutes), .seconds(seconds), .pm(pm), .sec_pulse(sec_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h = H0; m_m = 0; m_s = 0; m_pm = 0; m_pulse = 0; m_presc = 0; m_hq = 1; m_mq = 1;
  endtask

  task automatic hr_up();
`ifdef BINCLK_12H_EN
    m_h = m_h % 12 + 1;
    if (m_h == 12) m_pm ^= 1;
`else
    m_h = (m_h + 1) % 24;
`endif
  endtask

  // predict the next edge, queue it, then compare once the DUT has registered it
  task automatic step();
    exp_t e;
    int he, me, tk;
    he = int'(btn_hr) & (1 - m_hq);
    me = int'(btn_min) & (1 - m_mq);
    tk = (ena && m_presc == CLK_HZ - 1) ? 1 : 0;
    m_pulse = tk & ~he & ~me & 1;
    if (me != 0) begin
      m_m = (m_m + 1) % 60; m_s = 0; m_presc = 0;
    end else if (ena) m_presc = (m_presc + 1) % CLK_HZ;
    if (he != 0) hr_up();
    if (m_pulse != 0) begin
      m_s = (m_s + 1) % 60;
      if (m_s == 0) begin
        m_m = (m_m + 1) % 60;
        if (m_m == 0) hr_up();
      end
    end
    m_hq = int'(btn_hr); m_mq = int'(btn_min);
    sb.push_back('{m_h, m_m, m_s, m_pm, m_pulse});
    @(posedge clk); #1;
    e = sb.pop_front();
    check("hours", 32'(hours), e.h);
    check("minutes", 32'(minutes), e.m);
    check("seconds", 32'(seconds), e.s);
    check("pm", 32'(pm), e.pm);
    check("sec_pulse", 32'(sec_pulse), e.pulse);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input bit hr, input int n);
    for (int i = 0; i < n; i++) begin
      if (hr) btn_hr = 1'b1; else btn_min = 1'b1;
      step();
      btn_hr = 1'b0; btn_min = 1'b0;
      step();
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; ena = 1'b1; btn_hr = 1'b0; btn_min = 1'b0;
    model_reset();
    #3;
    check("rst_hours", 32'(hours), H0);
    check("rst_minutes", 32'(minutes), 0);
    check("rst_seconds", 32'(seconds), 0);
    check("rst_pulse", 32'(sec_pulse), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    steps(3);
    check("pre_tick_sec", 32'(seconds), 0);
    step();
    check("first_tick_sec", 32'(seconds), 1);
    check("first_tick_pulse", 32'(sec_pulse), 1);
    step();
    check("pulse_one_cycle", 32'(sec_pulse), 0);

    ena = 1'b0;
    press(1, HR_PRESS);
    press(0, 59);
    ena = 1'b1;
    steps(59 * CLK_HZ);
    check("pre_roll_h", 32'(hours), H_TOP);
    check("pre_roll_m", 32'(minutes), 59);
    check("pre_roll_s", 32'(seconds), 59);
    check("pre_roll_pm", 32'(pm), 0);
    steps(CLK_HZ);
    check("roll_h", 32'(hours), H0);
    check("roll_m", 32'(minutes), 0);
    check("roll_s", 32'(seconds), 0);
    check("roll_pulse", 32'(sec_pulse), 1);
    check("roll_pm", 32'(pm), PM_ROLL);

    steps(2);
    saved_s = 32'(seconds);
    ena = 1'b0;
    steps(10);
    check("freeze_s", 32'(seconds), saved_s);
    ena = 1'b1;
    step();
    check("resume_no_tick", 32'(sec_pulse), 0);
    step();
    check("resume_tick", 32'(sec_pulse), 1);
    check("resume_s", 32'(seconds), saved_s + 1);

    ena = 1'b0;
    press(0, 5);
    ena = 1'b1;
    steps(30 * CLK_HZ + 3);
    check("held_pre_m", 32'(minutes), 5);
    check("held_pre_s", 32'(seconds), 30);
    btn_min = 1'b1;
    step();
    check("held_m", 32'(minutes), 6);
    check("held_s", 32'(seconds), 0);
    check("held_no_pulse", 32'(sec_pulse), 0);
    steps(19);
    check("held_once", 32'(minutes), 6);
    btn_min = 1'b0;
    step();

    ena = 1'b0;
    press(1, 3);
    press(0, 4);
    ena = 1'b1;
    steps(20 * CLK_HZ + 3);
    check("sim_pre_h", 32'(hours), 3);
    check("sim_pre_s", 32'(seconds), 20);
    btn_hr = 1'b1;
    step();
    check("sim_h", 32'(hours), 4);
    check("sim_m", 32'(minutes), 10);
    check("sim_s", 32'(seconds), 20);
    check("sim_pulse", 32'(sec_pulse), 0);
    btn_hr = 1'b0;
    step();

    ena = 1'b0;
    press(1, 8);
    press(0, 24);
    ena = 1'b1;
    steps(56 * CLK_HZ);
    check("pre_rst_h", 32'(hours), 12);
    check("pre_rst_m", 32'(minutes), 34);
    check("pre_rst_s", 32'(seconds), 56);
    btn_hr = 1'b1;
    rst = 1'b1;
    model_reset();
    #2;
    check("async_h", 32'(hours), H0);
    check("async_m", 32'(minutes), 0);
    check("async_s", 32'(seconds), 0);
    check("async_pm", 32'(pm), 0);
    check("async_pulse", 32'(sec_pulse), 0);
    rst = 1'b0;
    steps(3);
    check("held_through_rst", 32'(hours), H0);
    btn_hr = 1'b0;
    step();
    btn_hr = 1'b1;
    step();
    check("repress_h", 32'(hours), 1);
    btn_hr = 1'b0;
    steps(2);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
